// File: rtl/apb4_pkg.sv
// Shared types for the queued APB4 master: FSM states, response status codes
// and the command record that travels through the command queue.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    RSP_OK      = 2'b00,
    RSP_SLVERR  = 2'b01,
    RSP_TIMEOUT = 2'b10
  } rsp_status_e;

  // The record is sized for the widest supported bus (32-bit address and data).
  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 32;
  localparam int CMD_STRB_MAX = CMD_DATA_MAX / 8;

  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] wdata;
    logic [CMD_STRB_MAX-1:0] strb;
    logic [2:0]              prot;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue: DEPTH-entry circular buffer with registered full/empty derived
// from pointers that carry one extra wrap bit.
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // NOTE: the storage array is deliberately left out of reset; the empty flag
  // gates every use of rdata, so stale contents are never observed.
  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/apb4_queued_master.sv
// APB4 requester fed from a command queue: issues queued commands in order,
// back-to-back when possible, and returns one response pulse per transfer.
module apb4_queued_master
  import apb4_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_status,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [2:0]              PPROT,
  input  logic                    PREADY,
  input  logic                    PSLVERR,
  input  logic [DATA_WIDTH-1:0]   PRDATA
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value seen on the final permitted wait edge.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  apb_state_e       state_q, state_d;
  rsp_status_e      rsp_status_q;
  apb_cmd_t         cmd_in, cmd_head;
  logic             fifo_full, fifo_empty, pop, xfer_end, timed_out;
  logic [CNT_W-1:0] wait_cnt_q;

  always_comb begin
    cmd_in       = '0;
    cmd_in.write = cmd_write;
    cmd_in.addr  = CMD_ADDR_MAX'(cmd_addr);
    cmd_in.wdata = CMD_DATA_MAX'(cmd_wdata);
    cmd_in.strb  = CMD_STRB_MAX'(cmd_strb);
    cmd_in.prot  = cmd_prot;
  end

  apb_cmd_fifo #(
    .WIDTH ($bits(apb_cmd_t)),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .push    (cmd_valid),
    .wdata   (cmd_in),
    .pop     (pop),
    .rdata   (cmd_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready  = !fifo_full;
  assign rsp_status = rsp_status_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    xfer_end  = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_SETUP;
          pop     = 1'b1;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (PREADY) begin
          xfer_end = 1'b1;
        end else if (TIMEOUT_CYCLES != 0 && wait_cnt_q == TO_LAST) begin
          xfer_end  = 1'b1;
          timed_out = 1'b1;
        end
        if (xfer_end) begin
          if (!fifo_empty) begin
            state_d = ST_SETUP;
            pop     = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      PSTRB        <= '0;
      PPROT        <= '0;
      wait_cnt_q   <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_status_q <= RSP_OK;
    end else begin
      rsp_valid <= xfer_end;
      if (xfer_end) begin
        rsp_status_q <= timed_out ? RSP_TIMEOUT : (PSLVERR ? RSP_SLVERR : RSP_OK);
        rsp_rdata    <= (!timed_out && !PWRITE) ? PRDATA : '0;
      end
      // PWRITE above still names the finishing transfer; the load below is non-blocking.
      if (pop) begin
        PSEL       <= 1'b1;
        PENABLE    <= 1'b0;
        PWRITE     <= cmd_head.write;
        PADDR      <= cmd_head.addr[ADDR_WIDTH-1:0];
        PWDATA     <= cmd_head.wdata[DATA_WIDTH-1:0];
        PSTRB      <= cmd_head.write ? cmd_head.strb[STRB_W-1:0] : '0;
        PPROT      <= cmd_head.prot;
        wait_cnt_q <= '0;
      end else if (state_q == ST_SETUP) begin
        PENABLE <= 1'b1;
      end else if (xfer_end) begin
        PSEL    <= 1'b0;
        PENABLE <= 1'b0;
      end else if (state_q == ST_ACCESS) begin
        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/apb4_queued_master.md
APB4_QUEUED_MASTER -- requirements
Module: apb4_queued_master

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, PADDR/cmd_addr width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width; legal values 8, 16, 32.
REQ-003 SHALL have parameter CMD_DEPTH, default 4, command queue entries; power of 2, ≥2.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, max ACCESS wait cycles; 0 disables timeout.
REQ-005 SHALL use reset PRESETn, asynchronous, active-low, and clock PCLK.
REQ-006 SHALL have ports:
- PCLK  in  1  clock.
- PRESETn  in  1  async active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  queue can accept.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  byte strobes.
- cmd_prot  in  3  protection.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_WIDTH  read data.
- rsp_status  out  2  00 OK, 01 SLVERR, 10 TIMEOUT.
- PSEL, PENABLE, PWRITE  out  1  APB control.
- PADDR  out  ADDR_WIDTH  address.
- PWDATA  out  DATA_WIDTH  write data.
- PSTRB  out  DATA_WIDTH/8  strobes.
- PPROT  out  3  protection.
- PREADY, PSLVERR  in  1  completer response.
- PRDATA  in  DATA_WIDTH  read data.

Function
REQ-007 SHALL accept a command on a rising edge where cmd_valid && cmd_ready; cmd_ready = queue not full, independent of cmd_valid.
REQ-008 SHALL store accepted commands in a CMD_DEPTH-entry FIFO and issue them in order; pointers wrap modulo CMD_DEPTH.
REQ-009 SHALL implement FSM IDLE, SETUP, ACCESS.
- IDLE→SETUP when queue non-empty, popping the head.
- SETUP→ACCESS unconditionally.
- ACCESS→SETUP when the transfer ends and the queue is non-empty (back-to-back, pop).
- ACCESS→IDLE when the transfer ends and the queue is empty.
REQ-010 SHALL drive all APB outputs from registers; PSEL=1,PENABLE=0 in SETUP; PSEL=1,PENABLE=1 in ACCESS; PADDR/PWRITE/PWDATA/PSTRB/PPROT stable from SETUP through the end of ACCESS.
REQ-011 SHALL drive PSTRB=0 for reads, regardless of cmd_strb.
REQ-012 SHALL, with an empty queue and IDLE, assert PSEL at the first edge after the acceptance edge; minimum transfer is 2 PCLK cycles.
REQ-013 SHALL end a transfer on an ACCESS edge with PREADY=1, pulse rsp_valid for exactly one cycle after that edge, and set rsp_status=01 if PSLVERR=1, else 00.
REQ-014 SHALL load rsp_rdata=PRDATA for reads; SHALL load 0 for writes and timeouts.
REQ-015 SHALL count ACCESS cycles with PREADY=0; when TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES, end the transfer with rsp_status=10; the counter clears on entering SETUP.
REQ-016 SHALL, for a simultaneous push and pop, accept both; a full queue becomes not full; cmd_ready stays 0 that cycle (registered-full based).
REQ-017 SHALL ignore PSLVERR and PRDATA outside ACCESS-with-PREADY edges.
REQ-018 SHALL keep rsp_valid=0 and rsp_rdata/rsp_status held between responses; there is no response backpressure.

Reset
REQ-019 SHALL, on PRESETn low, immediately set the FSM to IDLE, empty the queue, and set PSEL=PENABLE=PWRITE=0, PADDR=PWDATA=PSTRB=PPROT=0, rsp_valid=0, rsp_rdata=0, rsp_status=00, cmd_ready=1 (after reset), and the timeout counter to 0.
REQ-020 SHALL, on reset mid-transfer, abandon the transfer and queued commands without issuing a response.

Structure
REQ-021 SHALL place the state enum, the rsp_status encodings (OK/SLVERR/TIMEOUT), and a command struct typedef in package apb4_pkg.
REQ-022 SHALL implement the queue as sub-module apb_cmd_fifo (parametrised width/depth, full/empty flags); FSM, timeout, and response logic stay in the top.

Verification
REQ-023 SHALL cover a single write: addr 0x10, data 0xDEADBEEF, strb 0xF, PREADY=1 → SETUP 1 cycle, ACCESS 1 cycle, rsp_valid pulse, status 00, rsp_rdata 0.
REQ-024 SHALL cover a read with 3 wait states: PRDATA 0x12345678 → ACCESS lasts 4 cycles, rsp_rdata 0x12345678, status 00, PSTRB 0 throughout.
REQ-025 SHALL cover back-to-back: 4 writes pushed on consecutive cycles, PREADY=1 → cmd_ready drops when full, 4 SETUP/ACCESS pairs with no IDLE between, 4 in-order responses.
REQ-026 SHALL cover PSLVERR=1 on a read of 0x20 → status 01; the next queued command still issues.
REQ-027 SHALL cover a timeout: TIMEOUT_CYCLES=16, PREADY held 0 → after 16 ACCESS cycles, status 10, rsp_rdata 0, PSEL drops or the next SETUP follows.
REQ-028 SHALL cover PRESETn asserted in ACCESS with 2 queued commands → all APB outputs 0 asynchronously, no rsp_valid, queue empty after release.
